// File: rtl/sbox_bram_issue_collect.sv
// Issues 4 masked S-box lookups to a 2-port BRAM and collects a 32-bit word.
// Define SBOX_ZEROIZE_EN to clear share residue after each output handshake.
module sbox_bram_issue_collect #(
  parameter int ADDR_W   = 10,
  parameter int SEL_W    = 2,
  parameter int BRAM_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic [4*SEL_W-1:0] in_sel,
  output logic               bram_en,
  output logic [ADDR_W-1:0]  bram_addra,
  output logic [ADDR_W-1:0]  bram_addrb,
  input  logic [7:0]         bram_doa,
  input  logic [7:0]         bram_dob,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data
);

  localparam logic [1:0] WAIT_N =
    (BRAM_LAT > 2) ? 2'(BRAM_LAT - 2) : 2'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISS0,
    S_ISS1,
    S_WAIT,
    S_CAP0,
    S_CAP1,
    S_DONE
  } state_t;

  state_t             state;
  logic [1:0]         cnt;
  logic [15:0]        hi_q;
  logic [2*SEL_W-1:0] hsel_q;

  // Bytes 0/1 go straight to the address registers on accept,
  // so only the upper pair needs holding for the second issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      hi_q       <= '0;
      hsel_q     <= '0;
      in_ready   <= 1'b0;
      bram_en    <= 1'b0;
      bram_addra <= '0;
      bram_addrb <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            hi_q       <= in_data[31:16];
            hsel_q     <= in_sel[4*SEL_W-1:2*SEL_W];
            in_ready   <= 1'b0;
            bram_en    <= 1'b1;
            bram_addra <= {in_sel[0 +: SEL_W],
                           in_data[7:0]};
            bram_addrb <= {in_sel[SEL_W +: SEL_W],
                           in_data[15:8]};
            state      <= S_ISS0;
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_ISS0: begin
          bram_addra <= {hsel_q[0 +: SEL_W], hi_q[7:0]};
          bram_addrb <= {hsel_q[SEL_W +: SEL_W], hi_q[15:8]};
          state      <= S_ISS1;
        end
        S_ISS1: begin
          cnt <= '0;
          if (WAIT_N == 2'd0) begin
            state <= S_CAP0;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == WAIT_N - 2'd1) begin
            cnt   <= '0;
            state <= S_CAP0;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        S_CAP0: begin
          out_data[15:0] <= {bram_dob, bram_doa};
          state          <= S_CAP1;
        end
        S_CAP1: begin
          out_data[31:16] <= {bram_dob, bram_doa};
          bram_en         <= 1'b0;
          out_valid       <= 1'b1;
          state           <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
`ifdef SBOX_ZEROIZE_EN
            out_data   <= '0;
            hi_q       <= '0;
            hsel_q     <= '0;
            bram_addra <= '0;
            bram_addrb <= '0;
`endif
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_bram_issue_collect.sv
// Directed bench for sbox_bram_issue_collect with a 2-cycle BRAM model.
// Checks reset, latency, backpressure, streaming and SBOX_ZEROIZE_EN.
module tb_sbox_bram_issue_collect;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_sel;
  logic        bram_en;
  logic [9:0]  bram_addra;
  logic [9:0]  bram_addrb;
  logic [7:0]  bram_doa;
  logic [7:0]  bram_dob;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

  sbox_bram_issue_collect dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .bram_en    (bram_en),
    .bram_addra (bram_addra),
    .bram_addrb (bram_addrb),
    .bram_doa   (bram_doa),
    .bram_dob   (bram_dob),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] sbox(input logic [9:0] a);
    return a[7:0] ^ {6'b0, a[9:8]};
  endfunction

  function automatic logic [31:0] model(input logic [31:0] d,
                                        input logic [7:0] s);
    logic [31:0] r;
    for (int k = 0; k < 4; k++)
      r[8*k +: 8] = sbox({s[2*k +: 2], d[8*k +: 8]});
    return r;
  endfunction

  logic [7:0] ra, rb;
  always @(posedge clk) begin
    if (bram_en) begin
      ra       <= sbox(bram_addra);
      rb       <= sbox(bram_addrb);
      bram_doa <= ra;
      bram_dob <= rb;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk(tag, 64'(out_valid), 64'd1);
  endtask

  logic [31:0] w [8];
  logic [7:0]  s [8];
  int          lat;
  int          pulses;
  int          sent;
  int          recv;
  int          last;
  logic        acc;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    #3 rst = 1'b0;
    tick();
    tick();
    chk("rst_ctrl", 64'({in_ready, bram_en, out_valid}), 64'd0);
    chk("rst_addra", 64'(bram_addra), 64'd0);
    chk("rst_addrb", 64'(bram_addrb), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    rst = 1'b1;
    tick();
    chk("rel_ready", 64'(in_ready), 64'd1);

    // Test 1: reset while in ISS1
    in_data  = 32'h11223344;
    in_sel   = 8'h1B;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #3 rst = 1'b0;
    #1;
    chk("t1_async", 64'({in_ready, bram_en, out_valid}), 64'd0);
    chk("t1_async_addr", 64'({bram_addra, bram_addrb}), 64'd0);
    chk("t1_async_data", 64'(out_data), 64'd0);
    #2 rst = 1'b1;
    tick();
    chk("t1_ready", 64'(in_ready), 64'd1);
    chk("t1_outs", 64'({bram_en, out_valid, bram_addra, bram_addrb}), 64'd0);
    chk("t1_data", 64'(out_data), 64'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    chk("t1_no_out", 64'(pulses), 64'd0);

    // Test 2: basic word, latency
    in_data   = 32'hA1B2C3D4;
    in_sel    = 8'b11_10_01_00;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    lat = 1;
    in_valid = 1'b0;
    chk("t2_addra0", 64'(bram_addra), 64'h0D4);
    chk("t2_addrb0", 64'(bram_addrb), 64'h1C3);
    chk("t2_en", 64'({bram_en, in_ready}), 64'b10);
    tick();
    lat++;
    chk("t2_addra1", 64'(bram_addra), 64'h2B2);
    chk("t2_addrb1", 64'(bram_addrb), 64'h3A1);
    chk("t2_ov_early", 64'(out_valid), 64'd0);
    for (int i = 0; i < 10 && !out_valid; i++) begin
      tick();
      lat++;
    end
    chk("t2_latency", 64'(lat), 64'd5);
    chk("t2_data", 64'(out_data), 64'hA2B0C2D4);
    tick();
    chk("t2_hs", 64'({out_valid, in_ready, bram_en}), 64'b010);

    // Test 5: state after the output handshake
`ifdef SBOX_ZEROIZE_EN
    chk("t5_data", 64'(out_data), 64'd0);
    chk("t5_addr", 64'({bram_addra, bram_addrb}), 64'd0);
`else
    chk("t5_data", 64'(out_data), 64'hA2B0C2D4);
    chk("t5_addr", 64'({bram_addra, bram_addrb}),
        64'({10'h2B2, 10'h3A1}));
`endif

    // Test 3: backpressure
    in_data   = 32'h01020304;
    in_sel    = 8'hFF;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    chk("t3_addra", 64'(bram_addra), 64'h304);
    chk("t3_addrb", 64'(bram_addrb), 64'h303);
    in_data = 32'hDEADBEEF;
    in_sel  = 8'h00;
    wait_valid("t3_valid");
    chk("t3_data", 64'(out_data), 64'h02010007);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold", 64'({out_valid, in_ready, out_data}),
          64'({1'b1, 1'b0, 32'h02010007}));
    end
    out_ready = 1'b1;
    tick();
    chk("t3_release", 64'({out_valid, in_ready}), 64'b01);
    tick();
    chk("t3_accept", 64'({in_ready, bram_en}), 64'b01);
    chk("t3_addr2", 64'({bram_addra, bram_addrb}),
        64'({10'h0EF, 10'h0BE}));
    in_valid = 1'b0;
    wait_valid("t3_valid2");
    chk("t3_data2", 64'(out_data), 64'hDEADBEEF);
    tick();

    // Test 4: streaming
    for (int i = 0; i < 8; i++) begin
      w[i] = $urandom;
      s[i] = 8'($urandom_range(0, 255));
    end
    sent     = 0;
    recv     = 0;
    last     = 0;
    in_data  = w[0];
    in_sel   = s[0];
    in_valid = 1'b1;
    for (int c = 0; c < 200 && recv < 8; c++) begin
      acc = in_ready && in_valid;
      tick();
      if (acc) begin
        sent++;
        if (sent < 8) begin
          in_data = w[sent];
          in_sel  = s[sent];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        if (recv < 8)
          chk("t4_data", 64'(out_data), 64'(model(w[recv], s[recv])));
        if (recv > 0)
          chk("t4_gap", 64'(c - last), 64'd6);
        last = c;
        recv++;
      end
    end
    chk("t4_recv", 64'(recv), 64'd8);
    chk("t4_sent", 64'(sent), 64'd8);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
